// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package alu_muldiv_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  // ALU select codes that decode routes to this unit instead of the combinational ALU
  localparam logic [2:0] ALU_SEL_MUL = 3'd6;
  localparam logic [2:0] ALU_SEL_DIV = 3'd7;

  // op encoding on the request bus
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration counter width; it must hold WIDTH-1
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bus between execute-stage control and the multiply/divide unit.
import alu_muldiv_seq_pkg::*;

interface alu_muldiv_seq_if #(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  // Requester side (execute-stage control)
  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  // Unit side
  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_seq_dp.sv
// Datapath: shared WIDTH+1-bit adder plus the {acc,low} shift pair for
// shift-add multiply and restoring divide, one bit per step.
module alu_muldiv_seq_dp
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo_q,
  output logic [WIDTH-1:0] o_hi_c,
  output logic [WIDTH-1:0] o_lo_c
);
  localparam int unsigned SUM_W = WIDTH + 1;

  logic             r_op;
  logic [WIDTH-1:0] r_acc;   // mul: upper accumulator, div: partial remainder
  logic [WIDTH-1:0] r_low;   // mul: multiplier/product low, div: dividend/quotient
  logic [WIDTH-1:0] r_opnd;  // mul: multiplicand, div: divisor

  logic [SUM_W-1:0] w_add_x;
  logic [SUM_W-1:0] w_add_y;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_rem_sh;
  logic [WIDTH-1:0] w_quot_sh;

  // Adder operand select: accumulate for mul, trial-subtract for div
  always_comb begin
    w_rem_sh  = {r_acc, r_low[WIDTH-1]};
    w_quot_sh = {r_low[WIDTH-2:0], 1'b0};
    w_add_x   = '0;
    w_add_y   = '0;
    if (r_op == OP_DIV) begin
      w_add_x = w_rem_sh;
      w_add_y = ~{1'b0, r_opnd} + SUM_W'(1);
    end else begin
      w_add_x = {1'b0, r_acc};
      w_add_y = r_low[0] ? {1'b0, r_opnd} : '0;
    end
  end

  assign w_sum = w_add_x + w_add_y;

  // Next-step values; the partial remainder is below 2*divisor, so the top
  // bit of the difference is the borrow
  always_comb begin
    o_hi_c = r_acc;
    o_lo_c = r_low;
    if (r_op == OP_DIV) begin
      if (!w_sum[WIDTH]) begin
        o_hi_c = w_sum[WIDTH-1:0];
        o_lo_c = w_quot_sh | WIDTH'(1);
      end else begin
        o_hi_c = w_rem_sh[WIDTH-1:0];
        o_lo_c = w_quot_sh;
      end
    end else begin
      o_hi_c = w_sum[WIDTH:1];
      o_lo_c = {w_sum[0], r_low[WIDTH-1:1]};
    end
  end

  assign o_lo_q = r_low;

  // Operand load on accept, one iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_MUL;
      r_acc  <= '0;
      r_low  <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_op   <= i_op;
      r_acc  <= '0;
      r_low  <= (i_op == OP_DIV) ? i_a : i_b;
      r_opnd <= (i_op == OP_DIV) ? i_b : i_a;
    end else if (i_step) begin
      r_acc  <= o_hi_c;
      r_low  <= o_lo_c;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide unit: FSM, iteration counter and handshake;
// arithmetic lives in alu_muldiv_seq_dp.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_muldiv_seq_if.slave   bus
);
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic             r_dz_pend;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic             w_accept;
  logic             w_step;
  logic [WIDTH-1:0] w_lo_q;
  logic [WIDTH-1:0] w_hi_c;
  logic [WIDTH-1:0] w_lo_c;

  // Start is taken in IDLE or DONE; flush blocks a same-cycle start
  assign w_accept = bus.start && !bus.flush && (r_state != ST_RUN);
  assign w_step   = (r_state == ST_RUN) && !bus.flush && !r_dz_pend;

  alu_muldiv_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_step),
    .i_op   (bus.op),
    .i_a    (bus.operand_a),
    .i_b    (bus.operand_b),
    .o_lo_q (w_lo_q),
    .o_hi_c (w_hi_c),
    .o_lo_c (w_lo_c)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_dz      <= 1'b0;
            r_dz_pend <= (bus.op == OP_DIV) && (bus.operand_b == '0);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            // abort: no done, previous results kept
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_dz_pend <= 1'b0;
          end else if (r_dz_pend) begin
            // divide by zero finishes one cycle after accept; dividend held in dp low
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_dz      <= 1'b1;
            r_dz_pend <= 1'b0;
            r_lo      <= '1;
            r_hi      <= w_lo_q;
          end else if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_lo    <= w_lo_c;
            r_hi    <= w_hi_c;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_lo   = r_lo;
  assign bus.result_hi   = r_hi;
  assign bus.div_by_zero = r_dz;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_muldiv_seq;
  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int unsigned  cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_done   = 0;
  int unsigned busy_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain unsigned arithmetic; acc_edge is the edge that accepts start
  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned acc_edge);
    exp_t        e;
    logic [63:0] p;
    if (op == 1'b0) begin
      p     = {32'd0, a} * {32'd0, b};
      e.lo  = p[31:0];
      e.hi  = p[63:32];
      e.dz  = 1'b0;
      e.cyc = acc_edge + W;
    end else if (b == 0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dz  = 1'b1;
      e.cyc = acc_edge + 1;
    end else begin
      e.lo  = a / b;
      e.hi  = a % b;
      e.dz  = 1'b0;
      e.cyc = acc_edge + W;
    end
    return e;
  endfunction

  // Monitor: compare each done pulse with the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        n_done++;
        check("busy_low_in_done", 64'(bus.busy), 64'd0);
        if (q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("result_lo",   64'(bus.result_lo),   64'(mon_e.lo));
          check("result_hi",   64'(bus.result_hi),   64'(mon_e.hi));
          check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dz));
          check("done_cycle",  64'(cyc),             64'(mon_e.cyc));
          check("busy_cycles", 64'(busy_cnt),        mon_e.dz ? 64'd1 : 64'(W));
        end
        busy_cnt = 0;
      end else if (bus.busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
    end else begin
      busy_cnt = 0;
    end
  end

  // Drive one start pulse from a negedge; returns at the next negedge
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_done);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    if (expect_done) q.push_back(model(op, a, b, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("idle_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(bus.busy),        64'd0);
    check({tag, "_done"}, 64'(bus.done),        64'd0);
    check({tag, "_lo"},   64'(bus.result_lo),   64'd0);
    check({tag, "_hi"},   64'(bus.result_hi),   64'd0);
    check({tag, "_dz"},   64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    int unsigned d0;
    int unsigned n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;

    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.flush     = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations
    issue(1'b0, 32'd7, 32'd6, 1'b1);
    wait_idle();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    issue(1'b1, 32'd100, 32'd7, 1'b1);
    wait_idle();
    issue(1'b1, 32'd5, 32'd0, 1'b1);
    wait_idle();
    issue(1'b0, 32'd3, 32'd4, 1'b1);
    check("dz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);
    wait_idle();

    // Start pulse during RUN must be ignored
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (5) @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = 1'b1;
    bus.operand_a = 32'd77;
    bus.operand_b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Back-to-back: start held in the DONE cycle
    issue(1'b1, 32'd1000, 32'd3, 1'b1);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("b2b_done_timeout", 64'(bus.done), 64'd1);
    issue(1'b0, 32'd123, 32'd456, 1'b1);
    wait_idle();

    // Asynchronous reset at cycle 10 of a multiply
    issue(1'b0, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("midreset");
    d0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", 64'(n_done), 64'(d0));
    check("idle_after_reset", 64'(bus.busy), 64'd0);

    // Flush at cycle 5 keeps the previous results
    issue(1'b0, 32'd3, 32'd4, 1'b1);
    wait_idle();
    issue(1'b1, 32'hFFFF_0000, 32'd9, 1'b0);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    d0 = n_done;
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(n_done), 64'd0 + 64'(d0));
    check("flush_busy",    64'(bus.busy),        64'd0);
    check("flush_keep_lo", 64'(bus.result_lo),   64'd12);
    check("flush_keep_hi", 64'(bus.result_hi),   64'd0);
    check("flush_keep_dz", 64'(bus.div_by_zero), 64'd0);

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 1'b1);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
